// File: rtl/tdm_demux_if.sv
// Bundle for the 2:1 bit-interleaved TDM receive link.
// The master side drives the serial bit stream. The slave side returns the recovered words.
interface tdm_demux_if #(
    parameter int WIDTH = 8
) ();
    logic             m_in;
    logic             m_valid;
    logic             frame;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic             out_valid;
    logic             sync_err;

    modport master (
        output m_in, m_valid, frame,
        input  x_out, y_out, out_valid, sync_err
    );

    modport slave (
        input  m_in, m_valid, frame,
        output x_out, y_out, out_valid, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Receive end of a bit-interleaved 2:1 TDM link.
// Even slots carry channel x and odd slots carry channel y, LSB first.
module tdm_demux #(
    parameter int WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    tdm_demux_if.slave  bus
);
    localparam int SLOTS = 2 * WIDTH;
    localparam int SW    = $clog2(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t           state_reg, state_next;
    logic [SW-1:0]    slot_reg, slot_next, store_slot;
    logic [WIDTH-1:0] x_acc_reg, x_acc_next;
    logic [WIDTH-1:0] y_acc_reg, y_acc_next;
    logic [WIDTH-1:0] x_out_reg, y_out_reg;
    logic             done_reg, done_next;
    logic             out_valid_reg;
    logic             sync_err_reg, sync_err_next;
    logic             store_en, clear_acc;

    // A completed frame is published one edge after its last bit is stored.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= HUNT;
            slot_reg      <= '0;
            x_acc_reg     <= '0;
            y_acc_reg     <= '0;
            x_out_reg     <= '0;
            y_out_reg     <= '0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            x_acc_reg     <= x_acc_next;
            y_acc_reg     <= y_acc_next;
            done_reg      <= done_next;
            out_valid_reg <= done_reg;
            sync_err_reg  <= sync_err_next;
            if (done_reg) begin
                x_out_reg <= x_acc_reg;
                y_out_reg <= y_acc_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        if (bus.m_valid) begin
            case (state_reg)
                HUNT: begin
                    if (bus.frame) begin
                        state_next = RUN;
                        slot_next  = SW'(1);
                    end
                end
                RUN: begin
                    if (bus.frame) begin
                        slot_next = SW'(1);
                    end else if (slot_reg == '0) begin
                        state_next = HUNT;
                    end else if (slot_reg == LAST_SLOT) begin
                        slot_next = '0;
                    end else begin
                        slot_next = slot_reg + 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Any accepted frame marker restarts assembly at slot 0 and drops any partial frame.
    always_comb begin
        store_en      = 1'b0;
        clear_acc     = 1'b0;
        sync_err_next = 1'b0;
        done_next     = 1'b0;
        store_slot    = bus.frame ? '0 : slot_reg;
        if (bus.m_valid) begin
            case (state_reg)
                HUNT: begin
                    if (bus.frame) begin
                        store_en  = 1'b1;
                        clear_acc = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.frame) begin
                        store_en      = 1'b1;
                        clear_acc     = 1'b1;
                        sync_err_next = (slot_reg != '0);
                    end else if (slot_reg == '0) begin
                        sync_err_next = 1'b1;
                    end else begin
                        store_en  = 1'b1;
                        done_next = (slot_reg == LAST_SLOT);
                    end
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign x_acc_next[gi] = (store_en && store_slot == SW'(2 * gi))
                                    ? bus.m_in : (x_acc_reg[gi] & ~clear_acc);
            assign y_acc_next[gi] = (store_en && store_slot == SW'(2 * gi + 1))
                                    ? bus.m_in : (y_acc_reg[gi] & ~clear_acc);
        end
    endgenerate

    assign bus.x_out     = x_out_reg;
    assign bus.y_out     = y_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sync_err  = sync_err_reg;
endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: directed link scenarios plus randomized framing faults.
// Every output is compared each cycle against a queue-based model of the link.
module tb_tdm_demux;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tdm_demux_if #(.WIDTH(W)) bus ();

    tdm_demux #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a queue of bits received since the last frame marker.
    bit         aligned = 1'b0;
    bit         q[$];
    bit         pend = 1'b0;
    logic [W-1:0] pend_x = '0, pend_y = '0;
    logic [W-1:0] exp_x = '0, exp_y = '0;
    bit         exp_ov = 1'b0, exp_se = 1'b0;
    int         ov_cycles[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(bit rst, bit v, bit f, bit b);
        reset       = rst;
        bus.m_valid = v;
        bus.frame   = f;
        bus.m_in    = b;
        @(posedge clock);
        cyc++;
        exp_se = 1'b0;
        if (rst) begin
            aligned = 1'b0;
            q.delete();
            pend   = 1'b0;
            exp_ov = 1'b0;
            exp_x  = '0;
            exp_y  = '0;
        end else begin
            exp_ov = pend;
            if (pend) begin
                exp_x = pend_x;
                exp_y = pend_y;
            end
            pend = 1'b0;
            if (v) begin
                if (!aligned) begin
                    if (f) begin
                        aligned = 1'b1;
                        q.delete();
                        q.push_back(b);
                    end
                end else if (f) begin
                    if (q.size() != 0) exp_se = 1'b1;
                    q.delete();
                    q.push_back(b);
                end else if (q.size() == 0) begin
                    exp_se  = 1'b1;
                    aligned = 1'b0;
                end else begin
                    q.push_back(b);
                    if (q.size() == 2 * W) begin
                        for (int k = 0; k < W; k++) begin
                            pend_x[k] = q[2 * k];
                            pend_y[k] = q[2 * k + 1];
                        end
                        pend = 1'b1;
                        q.delete();
                    end
                end
            end
        end
        #1;
        chk("sync_err",  32'(bus.sync_err),  32'(exp_se));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("x_out",     32'(bus.x_out),     32'(exp_x));
        chk("y_out",     32'(bus.y_out),     32'(exp_y));
        if (bus.out_valid) begin
            ov_cycles.push_back(cyc);
            $display("cycle %0d word x=%h y=%h", cyc, bus.x_out, bus.y_out);
        end
        if (bus.sync_err) $display("cycle %0d sync_err", cyc);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Sends slots first..last of frame (x,y); 3 idle cycles follow slots g1 and g2.
    task automatic send_frame(logic [W-1:0] x, logic [W-1:0] y, int first, int last, int g1, int g2);
        for (int s = first; s <= last; s++) begin
            step(1'b0, 1'b1, s == 0, (s % 2 == 0) ? x[s / 2] : y[s / 2]);
            if (s == g1 || s == g2) idle(3);
        end
    endtask

    initial begin
        bus.m_valid = 1'b0;
        bus.frame   = 1'b0;
        bus.m_in    = 1'b0;

        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_x", 32'(bus.x_out), 32'h0);

        // Aligned frame
        send_frame(8'hA5, 8'h3C, 0, 15, -1, -1);
        chk("ov_not_early", 32'(bus.out_valid), 32'h0);
        idle(1);
        chk("aligned_x", 32'(bus.x_out), 32'hA5);
        chk("aligned_y", 32'(bus.y_out), 32'h3C);
        chk("aligned_ov", 32'(bus.out_valid), 32'h1);
        idle(2);

        // Gapped input
        send_frame(8'hA5, 8'h3C, 0, 15, 4, 11);
        idle(1);
        chk("gapped_ov", 32'(bus.out_valid), 32'h1);
        idle(2);

        // Back-to-back frames
        ov_cycles.delete();
        send_frame(8'hA5, 8'h3C, 0, 15, -1, -1);
        send_frame(8'hFF, 8'h01, 0, 15, -1, -1);
        idle(2);
        chk("b2b_count", 32'(ov_cycles.size()), 32'd2);
        if (ov_cycles.size() == 2)
            chk("b2b_spacing", 32'(ov_cycles[1] - ov_cycles[0]), 32'd16);
        chk("b2b_x", 32'(bus.x_out), 32'hFF);
        chk("b2b_y", 32'(bus.y_out), 32'h01);

        // Early frame marker at slot 7 starts the (0x12,0x34) frame
        send_frame(8'h77, 8'h99, 0, 6, -1, -1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("early_se", 32'(bus.sync_err), 32'h1);
        send_frame(8'h12, 8'h34, 1, 15, -1, -1);
        idle(1);
        chk("early_x", 32'(bus.x_out), 32'h12);
        chk("early_y", 32'(bus.y_out), 32'h34);

        // Missing frame marker, then unframed bits in HUNT
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("missing_se", 32'(bus.sync_err), 32'h1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("missing_hold_x", 32'(bus.x_out), 32'h12);

        // Reset at slot 9
        send_frame(8'hE7, 8'h81, 0, 8, -1, -1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("midrst_x", 32'(bus.x_out), 32'h0);
        idle(1);
        send_frame(8'h5A, 8'hC3, 0, 15, -1, -1);
        idle(1);
        chk("postrst_x", 32'(bus.x_out), 32'h5A);
        chk("postrst_y", 32'(bus.y_out), 32'hC3);

        // Random frames with gaps, misplaced or missing markers and occasional reset
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] rx, ry;
            int kind, at;
            rx   = W'($urandom);
            ry   = W'($urandom);
            kind = $urandom_range(0, 9);
            at   = $urandom_range(1, 2 * W - 1);
            for (int s = 0; s < 2 * W; s++) begin
                bit f, b, r;
                while ($urandom_range(0, 3) == 0) idle(1);
                b = (s % 2 == 0) ? rx[s / 2] : ry[s / 2];
                f = (s == 0);
                r = 1'b0;
                if (kind == 0 && s == 0) f = 1'b0;
                if (kind == 1 && s == at) f = 1'b1;
                if (kind == 2 && s == at) r = 1'b1;
                step(r, 1'b1, f, b);
            end
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the bits per channel word per frame.
REQ-002 The module SHALL have port clock, input, 1, the single rising-edge clock for all state.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port m_in, input, 1, the multiplexed serial data bit carrying channel x and channel y interleaved.
REQ-005 The module SHALL have port m_valid, input, 1, which qualifies m_in; a bit is consumed only on a cycle where m_valid=1.
REQ-006 The module SHALL have port frame, input, 1, which marks that the current valid bit is slot 0 of a frame; it is meaningful only when m_valid=1.
REQ-007 The module SHALL have port x_out, output, WIDTH, the last complete channel-x word, registered.
REQ-008 The module SHALL have port y_out, output, WIDTH, the last complete channel-y word, registered.
REQ-009 The module SHALL have port out_valid, output, 1, a one-cycle pulse when x_out and y_out update.
REQ-010 The module SHALL have port sync_err, output, 1, a one-cycle pulse on a framing violation.

Function
REQ-011 The block SHALL be the receive end of a bit-interleaved 2:1 link: slot counter 0..2*WIDTH-1; even slot k -> x bit k/2, odd slot k -> y bit (k-1)/2, LSB first.
REQ-012 The FSM SHALL have states HUNT (no frame alignment) and RUN (aligned, slot counter valid).
REQ-013 In HUNT, valid bits with frame=0 SHALL be discarded without any sync_err.
REQ-014 In HUNT, a valid bit with frame=1 SHALL be stored as slot 0 (x bit 0) and the FSM SHALL enter RUN with the slot counter at 1.
REQ-015 In RUN, each valid bit with frame=0 SHALL be stored at the current slot and the slot counter SHALL increment by 1.
REQ-016 When slot 2*WIDTH-1 is stored, on the next rising edge x_out/y_out SHALL load the assembled words and out_valid=1 for exactly one cycle (latency 1 clock after the last bit edge).
REQ-017 After slot 2*WIDTH-1 is stored, the slot counter SHALL wrap to 0 and the FSM SHALL stay in RUN expecting frame=1 on the next valid bit.
REQ-018 In RUN at slot 0, a valid bit with frame=1 SHALL be accepted as slot 0 of the next frame; back-to-back frames with no idle cycles SHALL be supported.
REQ-019 In RUN at slot 0, a valid bit with frame=0 SHALL pulse sync_err for one cycle, discard the bit and enter HUNT.
REQ-020 In RUN at slot != 0, a valid bit with frame=1 SHALL pulse sync_err, discard the partial frame, store the bit as slot 0 and set the slot counter to 1 (resync, stay RUN).
REQ-021 Cycles with m_valid=0 SHALL hold all state; frame and m_in SHALL be ignored on those cycles.
REQ-022 x_out and y_out SHALL hold their values between out_valid pulses; a partial or aborted frame SHALL never change them.
REQ-023 out_valid and sync_err SHALL never be 1 as a result of the same bit.

Reset
REQ-024 While reset=1 at a clock edge: state=HUNT, slot counter=0, shift registers=0, x_out=0, y_out=0, out_valid=0, sync_err=0.
REQ-025 Reset SHALL take priority over m_valid/frame on the same edge; a frame in progress SHALL be discarded with no out_valid and no sync_err.
REQ-026 The first valid bit after reset deasserts SHALL be processed under the HUNT rules.

Verification
REQ-027 Aligned frame: WIDTH=8, x=0xA5, y=0x3C, 16 consecutive valid bits, frame=1 on bit 0 (slot order x0,y0,x1,y1,...) -> one edge after bit 15: x_out=0xA5, y_out=0x3C, out_valid pulses once, sync_err=0.
REQ-028 Gapped input: same frame with m_valid=0 inserted for 3 cycles after slots 4 and 11 -> identical outputs, out_valid one edge after the last valid bit.
REQ-029 Back-to-back frames: (0xA5,0x3C) then (0xFF,0x01) with no gap -> two out_valid pulses exactly 16 cycles apart carrying those values.
REQ-030 Early frame: frame=1 at slot 7, then a full 16-bit frame (0x12,0x34) -> sync_err pulse at the slot-7 bit, no output for the aborted frame, then x_out=0x12, y_out=0x34.
REQ-031 Missing frame: after a complete frame, the next valid bit has frame=0 -> sync_err pulse, HUNT; following valid bits without frame produce no pulses; outputs are unchanged.
REQ-032 Reset mid-frame: reset=1 at slot 9 -> all outputs 0; a subsequent aligned frame (0x5A,0xC3) yields x_out=0x5A, y_out=0xC3 with no sync_err.
